updown_mod_counter: RTL and testbench

Parametrised synchronous modulo-N up/down counter with enable, synchronous clear, parallel load, terminal-count and wrap outputs. It is the general-purpose successor to the team's fixed 4-bit binary up-counter. Width, modulus and direction are configurable, and counters cascade through `tc`. It serves as a timebase, divider and event counter in the simulation designs.

---
 rtl/updown_mod_counter_pkg.sv | 15 +
 rtl/updown_mod_counter_if.sv | 23 ++
 rtl/updown_mod_counter_reg.sv | 20 ++
 rtl/updown_mod_counter.sv | 74 +++++++
 tb/tb_updown_mod_counter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter family.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Saturates a requested load value into the legal count range 0..modulus-1.
    function automatic logic [63:0] clamp_load(input logic [63:0] value,
                                               input logic [63:0] modulus);
        logic [63:0] max_value;
        max_value = modulus - 64'd1;
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of one modulo up/down counter stage.
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             up_down;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] outQ;
    logic             tc;
    logic             wrap;

    modport master (
        output enable, up_down, clear, load, load_value,
        input  outQ, tc, wrap
    );

    modport slave (
        input  enable, up_down, clear, load, load_value,
        output outQ, tc, wrap
    );
endinterface

// File: rtl/updown_mod_counter_reg.sv
// Register with asynchronous active-high reset to zero and a load enable.
module counter_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-N up/down counter with clear, clamped load, combinational tc for
// cascading and a registered one-cycle wrap pulse.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    updown_mod_counter_if.slave      bus
);

    if (WIDTH < 1 || MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_param
        $fatal(1, "updown_mod_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    logic             count_en;
    logic             wrap_next;
    logic             wrap_q;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (count == MAX);
    assign at_zero = (count == '0);

    always_comb begin
        count_next = count;
        count_en   = 1'b0;
        wrap_next  = 1'b0;
        if (bus.clear) begin
            count_next = '0;
            count_en   = 1'b1;
        end else if (bus.load) begin
            count_next = WIDTH'(clamp_load(64'(bus.load_value), 64'(MODULUS)));
            count_en   = 1'b1;
        end else if (bus.enable) begin
            count_en = 1'b1;
            if (bus.up_down == DIR_UP) begin
                count_next = at_max ? '0 : count + WIDTH'(1);
                wrap_next  = at_max;
            end else begin
                count_next = at_zero ? MAX : count - WIDTH'(1);
                wrap_next  = at_zero;
            end
        end
    end

    counter_reg #(.WIDTH(WIDTH)) u_count_reg (
        .clk   (clk),
        .reset (reset),
        .en    (count_en),
        .d     (count_next),
        .q     (count)
    );

    // The wrap flop reloads every edge so the pulse never outlives one cycle.
    counter_reg #(.WIDTH(1)) u_wrap_reg (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (wrap_next),
        .q     (wrap_q)
    );

    assign bus.outQ = count;
    assign bus.wrap = wrap_q;
    assign bus.tc   = bus.enable & ((bus.up_down & at_max) | (~bus.up_down & at_zero));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for a two-stage cascade of WIDTH=4, MODULUS=10 counters against a modulo-arithmetic model.
module tb_updown_mod_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic clk;
    logic reset;

    updown_mod_counter_if #(.WIDTH(W)) bus ();
    updown_mod_counter_if #(.WIDTH(W)) bus_hi ();

    updown_mod_counter #(.WIDTH(W), .MODULUS(MOD)) u_lo (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    updown_mod_counter #(.WIDTH(W), .MODULUS(MOD)) u_hi (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_hi)
    );

    assign bus_hi.enable = bus.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: count value and wrap flag of each stage.
    int m, hm;
    bit w, hw;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_lo_q"},    32'(bus.outQ),    32'(m));
        check({tag, "_lo_wrap"}, 32'(bus.wrap),    32'(w));
        check({tag, "_hi_q"},    32'(bus_hi.outQ), 32'(hm));
        check({tag, "_hi_wrap"}, 32'(bus_hi.wrap), 32'(hw));
    endtask

    task automatic step(input bit en, input bit ud, input bit clr, input bit ld,
                        input int lv, input bit hclr, input string tag);
        bit exp_tc;
        @(negedge clk);
        bus.enable     = en;
        bus.up_down    = ud;
        bus.clear      = clr;
        bus.load       = ld;
        bus.load_value = W'(lv);
        bus_hi.clear   = hclr;
        #1;
        exp_tc = en && ((ud && m == MOD - 1) || (!ud && m == 0));
        check({tag, "_tc"}, 32'(bus.tc), 32'(exp_tc));
        @(posedge clk);
        if (clr) begin
            m = 0; w = 0;
        end else if (ld) begin
            m = (lv > MOD - 1) ? MOD - 1 : lv; w = 0;
        end else if (en) begin
            if (ud) begin
                w = (m + 1 >= MOD); m = (m + 1) % MOD;
            end else begin
                w = (m == 0); m = (m + MOD - 1) % MOD;
            end
        end else begin
            w = 0;
        end
        if (hclr) begin
            hm = 0; hw = 0;
        end else if (exp_tc) begin
            hw = (hm + 1 >= MOD); hm = (hm + 1) % MOD;
        end else begin
            hw = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        m = 0; w = 0; hm = 0; hw = 0;
        check_outputs(tag);
        check({tag, "_tc"}, 32'(bus.tc), 32'(bus.enable & ~bus.up_down));
        bus.enable = 1'b0;
        bus.clear  = 1'b0;
        bus.load   = 1'b0;
        bus_hi.clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0; bus.up_down = 1'b1; bus.clear = 1'b0;
        bus.load = 1'b0; bus.load_value = '0;
        bus_hi.up_down = 1'b1; bus_hi.clear = 1'b0;
        bus_hi.load = 1'b0; bus_hi.load_value = '0;
        m = 0; w = 0; hm = 0; hw = 0;

        #3;
        check_outputs("rst");
        check("rst_tc_idle", 32'(bus.tc), 32'd0);
        bus.enable = 1'b1; bus.up_down = 1'b0;
        #1;
        check("rst_tc_down", 32'(bus.tc), 32'd1);
        bus.enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, "up4");
        @(negedge clk);
        #2;
        async_reset("midrst");
        step(1, 1, 0, 0, 0, 0, "resume");

        step(0, 1, 1, 0, 0, 1, "clr");
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0, 0, "up12");

        step(0, 1, 1, 0, 0, 1, "clr2");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, "down3");

        step(0, 1, 0, 1, 5, 0, "load5");
        step(0, 1, 0, 1, 12, 0, "load12");
        step(1, 1, 1, 1, 7, 0, "load_clr");
        step(1, 1, 0, 1, 3, 0, "load_en");

        step(0, 1, 0, 1, 9, 0, "load9");
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, "hold");
        step(1, 0, 0, 0, 0, 0, "flip");

        // Wrap pulse cut short by reset.
        step(0, 1, 0, 1, 9, 0, "pre_wrap");
        step(1, 1, 0, 0, 0, 0, "wrap");
        #2;
        async_reset("wraprst");

        step(0, 1, 1, 0, 0, 1, "cas_clr");
        for (int i = 0; i < 105; i++) step(1, 1, 0, 0, 0, 0, "cascade");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                @(negedge clk);
                #2;
                async_reset("rnd_rst");
            end
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 15)), $urandom_range(0, 31) == 0, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
